vga_timing: RTL and testbench

Generates the 640x480@60 Hz VGA raster from the 50 MHz system clock: a pixel-rate enable, horizontal/vertical raw counters `x`/`y`, active-low sync pulses and an active-area flag. It sits directly upstream of the per-pixel colour stage (`color_xy`), which consumes `x`, `y` and compares them against the screen centre (368, 273) to split quadrants. It also drives the DAC control lines. Counter origin is the start of back porch, so the active area begins at x=48, y=33.

---
 rtl/vga_timing_if.sv | 38 +++
 rtl/vga_timing.sv | 110 +++++++++++
 tb/tb_vga_timing.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and the per-pixel
// colour stage.
//
// Qualifier semantics: this is a free-running stream with no backpressure.
// pix_en marks the clk cycles on which the stage advances. x, y, hsync_n,
// vsync_n and blank_n are stable for two clk cycles and change only on the
// edge after a pix_en=1 cycle. frame_start is a single-clk pulse on the first
// pixel tick of each frame. The consumer must sample x/y in the cycle they
// are presented and must never stall the producer.
interface vga_timing_if;
  logic       pix_en;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync_n;
  logic       vsync_n;
  logic       blank_n;
  logic       frame_start;

  modport master (
    output pix_en,
    output x,
    output y,
    output hsync_n,
    output vsync_n,
    output blank_n,
    output frame_start
  );

  modport slave (
    input pix_en,
    input x,
    input y,
    input hsync_n,
    input vsync_n,
    input blank_n,
    input frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 Hz VGA raster generator running from the 50 MHz system clock.
// The counter origin is the start of back porch, so the active area begins
// at (H_BP, V_BP). Sync and blank are registered from the next-state counter
// values, so they line up with the presented x/y with zero skew.
module vga_timing #(
  parameter int H_BP   = 48,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int V_BP   = 33,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2
) (
  input  logic  clk,
  input  logic  reset,
  vga_timing_if.master vga
);

  localparam int H_TOT = H_BP + H_ACT + H_FP + H_SYNC;
  localparam int V_TOT = V_BP + V_ACT + V_FP + V_SYNC;

  // Segment boundaries as 10-bit constants so every compare is width-matched.
  localparam logic [9:0] H_LAST      = 10'(H_TOT - 1);
  localparam logic [9:0] H_ACT_BEG   = 10'(H_BP);
  localparam logic [9:0] H_ACT_END   = 10'(H_BP + H_ACT);
  localparam logic [9:0] H_SYNC_BEG  = 10'(H_BP + H_ACT + H_FP);
  localparam logic [9:0] V_LAST      = 10'(V_TOT - 1);
  localparam logic [9:0] V_ACT_BEG   = 10'(V_BP);
  localparam logic [9:0] V_ACT_END   = 10'(V_BP + V_ACT);
  localparam logic [9:0] V_SYNC_BEG  = 10'(V_BP + V_ACT + V_FP);

  logic       pix_en_q;
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic       hsync_n_q;
  logic       vsync_n_q;
  logic       blank_n_q;

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       hsync_n_nxt;
  logic       vsync_n_nxt;
  logic       blank_n_nxt;

  // Next counter values: advance on pixel ticks, wrap by explicit compare.
  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (pix_en_q) begin
      if (x_q == H_LAST) begin
        x_nxt = 10'd0;
        if (y_q == V_LAST) begin
          y_nxt = 10'd0;
        end else begin
          y_nxt = y_q + 10'd1;
        end
      end else begin
        x_nxt = x_q + 10'd1;
      end
    end
  end

  // Sync and blank decoded from the next-state counters so they register
  // alongside the counters they describe.
  always_comb begin
    hsync_n_nxt = 1'b1;
    vsync_n_nxt = 1'b1;
    blank_n_nxt = 1'b0;
    if ((x_nxt >= H_SYNC_BEG) && (x_nxt <= H_LAST)) begin
      hsync_n_nxt = 1'b0;
    end
    if ((y_nxt >= V_SYNC_BEG) && (y_nxt <= V_LAST)) begin
      vsync_n_nxt = 1'b0;
    end
    if ((x_nxt >= H_ACT_BEG) && (x_nxt < H_ACT_END) &&
        (y_nxt >= V_ACT_BEG) && (y_nxt < V_ACT_END)) begin
      blank_n_nxt = 1'b1;
    end
  end

  // State registers; reset wins over counting on every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en_q  <= 1'b0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      pix_en_q  <= ~pix_en_q;
      x_q       <= x_nxt;
      y_q       <= y_nxt;
      hsync_n_q <= hsync_n_nxt;
      vsync_n_q <= vsync_n_nxt;
      blank_n_q <= blank_n_nxt;
    end
  end

  assign vga.pix_en      = pix_en_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.hsync_n     = hsync_n_q;
  assign vga.vsync_n     = vsync_n_q;
  assign vga.blank_n     = blank_n_q;
  // Only one pixel tick per frame has x=0,y=0, so this is a one-clk pulse.
  assign vga.frame_start = pix_en_q & (x_q == 10'd0) & (y_q == 10'd0);

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: one instance with the real 640x480 timing for the
// startup and line-level checks, and one instance with a shrunken raster
// (16x9 totals) so whole frames fit into a short run.
module tb_vga_timing;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_timing_if vd ();
  vga_timing_if vsm ();

  vga_timing u_def (
    .clk   (clk),
    .reset (reset),
    .vga   (vd)
  );

  vga_timing #(
    .H_BP(3), .H_ACT(8), .H_FP(2), .H_SYNC(3),
    .V_BP(2), .V_ACT(4), .V_FP(1), .V_SYNC(2)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .vga   (vsm)
  );

  // ---------------------------------------------------------------- types
  typedef struct packed {
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       fs;
  } obs_t;

  typedef struct {
    int   k;    // clk cycles after reset release (0 = first cycle)
    bit   sm;   // 1 = small instance, 0 = full-size instance
    obs_t exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  int checks = 0;
  int failures = 0;
  int exp_q[$];   // expected frame_start cycle indices for the small raster

  // ---------------------------------------------------------------- helpers
  function automatic obs_t mk(input logic pe, input int x, input int y,
                              input logic hs, input logic vs, input logic bn,
                              input logic fs);
    obs_t o;
    o.pe = pe; o.x = 10'(x); o.y = 10'(y);
    o.hs = hs; o.vs = vs; o.bn = bn; o.fs = fs;
    return o;
  endfunction

  function automatic obs_t get_def();
    return mk(vd.pix_en, int'(vd.x), int'(vd.y), vd.hsync_n, vd.vsync_n,
              vd.blank_n, vd.frame_start);
  endfunction

  function automatic obs_t get_small();
    return mk(vsm.pix_en, int'(vsm.x), int'(vsm.y), vsm.hsync_n, vsm.vsync_n,
              vsm.blank_n, vsm.frame_start);
  endfunction

  // Closed-form raster model: pixel index p = (k+1)/2 since release.
  function automatic obs_t model(input int k, input int hbp, input int hact,
                                 input int hfp, input int hsy, input int vbp,
                                 input int vact, input int vfp, input int vsy);
    int htot, vtot, p, xi, yi;
    logic pe;
    htot = hbp + hact + hfp + hsy;
    vtot = vbp + vact + vfp + vsy;
    p  = (k + 1) / 2;
    xi = p % htot;
    yi = (p / htot) % vtot;
    pe = ((k % 2) == 0);
    return mk(pe, xi, yi,
              !(xi >= hbp + hact + hfp),
              !(yi >= vbp + vact + vfp),
              (xi >= hbp) && (xi < hbp + hact) && (yi >= vbp) && (yi < vbp + vact),
              pe && (xi == 0) && (yi == 0));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_obs(input string name, input int k, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d: got pe=%b x=%0d y=%0d hs=%b vs=%b bn=%b fs=%b expected pe=%b x=%0d y=%0d hs=%b vs=%b bn=%b fs=%b",
               name, k, act.pe, act.x, act.y, act.hs, act.vs, act.bn, act.fs,
               exp.pe, exp.x, exp.y, exp.hs, exp.vs, exp.bn, exp.fs);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    obs_t r;
    r = mk(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp_obs({tag, "_def"}, -1, get_def(), r);
    cmp_obs({tag, "_small"}, -1, get_small(), r);
  endtask

  // ---------------------------------------------------------------- driver
  // Runs ncyc cycles after a reset release, comparing both instances to the
  // model every cycle, plus directed vectors and segment measurements.
  task automatic run_phase(input int ncyc);
    obs_t a, e;
    int   vi = 0;
    int   def_fall_k = -1;
    logic def_hs_prev = 1'b1;
    int   def_hs_low = 0;
    logic sm_vs_prev = 1'b1;
    int   sm_vs_low = 0;
    logic sm_bn_prev = 1'b0;
    int   sm_bn_ticks = 0;
    logic seen_fs = 1'b0;

    exp_q.delete();
    for (int f = 0; f * 288 < ncyc; f++) exp_q.push_back(f * 288);

    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      cmp_obs("def_model", k, get_def(), model(k, 48, 640, 16, 96, 33, 480, 10, 2));
      cmp_obs("small_model", k, get_small(), model(k, 3, 8, 2, 3, 2, 4, 1, 2));

      if (vi < NV) begin
        if (vecs[vi].k == k) begin
          a = vecs[vi].sm ? get_small() : get_def();
          e = vecs[vi].exp;
          cmp_obs(vecs[vi].sm ? "vec_small" : "vec_def", k, a, e);
          vi++;
        end
      end

      // Full-size line timing from hsync_n edges.
      if (def_hs_prev && !vd.hsync_n) begin
        check("def_hs_fall_x", int'(vd.x), 704);
        if (def_fall_k >= 0) check("def_line_period", k - def_fall_k, 1600);
        def_fall_k = k;
        def_hs_low = 0;
      end
      if (!vd.hsync_n) def_hs_low++;
      if (!def_hs_prev && vd.hsync_n) check("def_hs_low_len", def_hs_low, 192);
      def_hs_prev = vd.hsync_n;

      // Small-raster vertical sync edges.
      if (sm_vs_prev && !vsm.vsync_n) begin
        check("sm_vs_fall_x", int'(vsm.x), 0);
        check("sm_vs_fall_y", int'(vsm.y), 7);
        sm_vs_low = 0;
      end
      if (!vsm.vsync_n) sm_vs_low++;
      if (!sm_vs_prev && vsm.vsync_n) begin
        check("sm_vs_low_len", sm_vs_low, 64);
        check("sm_vs_rise_xy", int'(vsm.x) + int'(vsm.y), 0);
      end
      sm_vs_prev = vsm.vsync_n;

      // Small-raster active window edges.
      if (!sm_bn_prev && vsm.blank_n) check("sm_bn_rise_x", int'(vsm.x), 3);
      if (sm_bn_prev && !vsm.blank_n) check("sm_bn_fall_x", int'(vsm.x), 11);
      sm_bn_prev = vsm.blank_n;

      // Active pixel ticks per frame, and frame_start scoreboard.
      if (vsm.frame_start) begin
        if (seen_fs) check("sm_active_ticks", sm_bn_ticks, 32);
        sm_bn_ticks = 0;
        seen_fs = 1'b1;
        if (exp_q.size() == 0) check("sm_fs_unexpected", k, -1);
        else check("sm_fs_time", k, exp_q.pop_front());
      end
      if (vsm.pix_en && vsm.blank_n) sm_bn_ticks++;
    end
    check("sm_fs_missing", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    int guard;
    // Hand-computed vectors, sorted by k.
    vecs[0]  = '{0,    1'b0, mk(1, 0,   0, 1, 1, 0, 1)};
    vecs[1]  = '{1,    1'b0, mk(0, 1,   0, 1, 1, 0, 0)};
    vecs[2]  = '{2,    1'b0, mk(1, 1,   0, 1, 1, 0, 0)};
    vecs[3]  = '{3,    1'b0, mk(0, 2,   0, 1, 1, 0, 0)};
    vecs[4]  = '{63,   1'b1, mk(0, 0,   2, 1, 1, 0, 0)};
    vecs[5]  = '{69,   1'b1, mk(0, 3,   2, 1, 1, 1, 0)};
    vecs[6]  = '{84,   1'b1, mk(1, 10,  2, 1, 1, 1, 0)};
    vecs[7]  = '{85,   1'b1, mk(0, 11,  2, 1, 1, 0, 0)};
    vecs[8]  = '{95,   1'b0, mk(0, 48,  0, 1, 1, 0, 0)};
    vecs[9]  = '{223,  1'b1, mk(0, 0,   7, 1, 0, 0, 0)};
    vecs[10] = '{255,  1'b1, mk(0, 0,   8, 1, 0, 0, 0)};
    vecs[11] = '{286,  1'b1, mk(1, 15,  8, 0, 0, 0, 0)};
    vecs[12] = '{287,  1'b1, mk(0, 0,   0, 1, 1, 0, 0)};
    vecs[13] = '{288,  1'b1, mk(1, 0,   0, 1, 1, 0, 1)};
    vecs[14] = '{1375, 1'b0, mk(0, 688, 0, 1, 1, 0, 0)};
    vecs[15] = '{1406, 1'b0, mk(1, 703, 0, 1, 1, 0, 0)};
    vecs[16] = '{1407, 1'b0, mk(0, 704, 0, 0, 1, 0, 0)};
    vecs[17] = '{1598, 1'b0, mk(1, 799, 0, 0, 1, 0, 0)};
    vecs[18] = '{1599, 1'b0, mk(0, 0,   1, 1, 1, 0, 0)};
    vecs[19] = '{1600, 1'b0, mk(1, 0,   1, 1, 1, 0, 0)};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_hold");
    reset = 1'b0;
    run_phase(3200);

    // Mid-frame reset on the small raster at x=6, y=4.
    guard = 0;
    while (!(vsm.x == 10'd6 && vsm.y == 10'd4) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("mid_reset_wait_timeout", int'(guard < 2000), 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");
    reset = 1'b0;
    run_phase(1700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
